// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the decode stage. A raw 32-bit instruction
// plus a format select is turned into a fully extended XLEN-bit immediate
// (I, S, B, U, J, shift amount, CSR uimm). The result is registered in an
// output register (OR) backed by a one-entry skid register (SK), so the
// downstream can stall without losing instructions. in_ready depends only on
// registered state.
//
// Ports:
//   clk, rst_n          clock (rising edge) / async active-low reset
//   in_valid, in_ready  upstream handshake
//   instr, imm_sel      raw instruction and format select (7 = illegal)
//   tag_in              sideband tag, passed through unmodified
//   out_valid, out_ready downstream handshake
//   imm, fmt_err, tag_out result of the entry at the head of the pipe
//   err_clr             synchronous clear of err_cnt (wins over increment)
//   err_cnt             saturating count of accepted illegal selects
//
// XLEN must be 32 or 64.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [2:0]           imm_sel,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      imm,
  output logic                 fmt_err,
  output logic [TAG_W-1:0]     tag_out,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  // Extension is always done to 64 bits and then truncated, which keeps the
  // concatenations fixed-width for both legal XLEN values.
  logic [63:0]      ext64;
  logic             new_err;
  logic [XLEN-1:0]  new_imm;

  always_comb begin
    ext64   = '0;
    new_err = 1'b0;
    case (imm_sel)
      3'd0: ext64 = {{52{instr[31]}}, instr[31:20]};
      3'd1: ext64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      3'd2: ext64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25],
                     instr[11:8], 1'b0};
      3'd3: ext64 = {{32{instr[31]}}, instr[31:12], 12'h000};
      3'd4: ext64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20],
                     instr[30:21], 1'b0};
      3'd5: ext64 = (XLEN == 64) ? {58'd0, instr[25:20]}
                                 : {59'd0, instr[24:20]};
      3'd6: ext64 = {59'd0, instr[19:15]};
      default: begin
        ext64   = '0;
        new_err = 1'b1;
      end
    endcase
  end

  assign new_imm = ext64[XLEN-1:0];

  // Opcode bits and (for XLEN=32) the upper extension half are not needed.
  logic unused_bits;
  assign unused_bits = ^{instr[6:0], ext64};

  // Output register and skid register.
  logic             or_valid_reg, sk_valid_reg;
  logic [XLEN-1:0]  or_imm_reg,   sk_imm_reg;
  logic             or_err_reg,   sk_err_reg;
  logic [TAG_W-1:0] or_tag_reg,   sk_tag_reg;

  logic accept;
  logic drain;

  assign in_ready = !sk_valid_reg;
  assign accept   = in_valid && in_ready;
  assign drain    = or_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid_reg <= 1'b0;
      or_imm_reg   <= '0;
      or_err_reg   <= 1'b0;
      or_tag_reg   <= '0;
      sk_valid_reg <= 1'b0;
      sk_imm_reg   <= '0;
      sk_err_reg   <= 1'b0;
      sk_tag_reg   <= '0;
    end else if (drain && sk_valid_reg) begin
      // SK refills OR; no accept is possible here because in_ready is low.
      or_imm_reg   <= sk_imm_reg;
      or_err_reg   <= sk_err_reg;
      or_tag_reg   <= sk_tag_reg;
      sk_valid_reg <= 1'b0;
    end else if (accept && (!or_valid_reg || out_ready)) begin
      or_valid_reg <= 1'b1;
      or_imm_reg   <= new_imm;
      or_err_reg   <= new_err;
      or_tag_reg   <= tag_in;
    end else if (accept) begin
      // OR is holding a stalled result: park the new one in SK.
      sk_valid_reg <= 1'b1;
      sk_imm_reg   <= new_imm;
      sk_err_reg   <= new_err;
      sk_tag_reg   <= tag_in;
    end else if (drain) begin
      // Data is left in place; only the valid bit drops.
      or_valid_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && new_err && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign out_valid = or_valid_reg;
  assign imm       = or_imm_reg;
  assign fmt_err   = or_err_reg;
  assign tag_out   = or_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [7:0]  tag_in;
  logic        out_ready;
  logic        err_clr;

  logic        v32, ir32, ov32, fe32;
  logic [31:0] imm32;
  logic [7:0]  to32;
  logic [7:0]  ec32;

  logic        v64, ir64, ov64, fe64;
  logic [63:0] imm64;
  logic [7:0]  to64;
  logic [1:0]  ec64;

  // Expected result of the stimulus currently being driven.
  logic [63:0] exp_imm;
  logic        exp_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] imm;
    logic        err;
    logic [7:0]  tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ERR_CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(ir32),
    .instr(instr), .imm_sel(imm_sel), .tag_in(tag_in),
    .out_valid(ov32), .out_ready(out_ready), .imm(imm32),
    .fmt_err(fe32), .tag_out(to32), .err_clr(err_clr), .err_cnt(ec32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .ERR_CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(ir64),
    .instr(instr), .imm_sel(imm_sel), .tag_in(tag_in),
    .out_valid(ov64), .out_ready(out_ready), .imm(imm64),
    .fmt_err(fe64), .tag_out(to64), .err_clr(err_clr), .err_cnt(ec64)
  );

  task automatic check(input string name, input logic [63:0] obs,
                       input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Scoreboard: pop/compare on output handshake, push on input handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ov32 && out_ready) begin
        if (q32.size() == 0) check("sb32_unexpected_out", 64'(to32), 64'hDEAD);
        else begin
          e = q32.pop_front();
          check("sb32_imm", {32'd0, imm32}, e.imm);
          check("sb32_err", 64'(fe32), 64'(e.err));
          check("sb32_tag", 64'(to32), 64'(e.tag));
          $display("[TB] dut32 out tag=%0d imm=%h fmt_err=%0b", to32, imm32, fe32);
        end
      end
      if (v32 && ir32) q32.push_back('{{32'd0, exp_imm[31:0]}, exp_err, tag_in});
      if (ov64 && out_ready) begin
        if (q64.size() == 0) check("sb64_unexpected_out", 64'(to64), 64'hDEAD);
        else begin
          e = q64.pop_front();
          check("sb64_imm", imm64, e.imm);
          check("sb64_err", 64'(fe64), 64'(e.err));
          check("sb64_tag", 64'(to64), 64'(e.tag));
          $display("[TB] dut64 out tag=%0d imm=%h fmt_err=%0b", to64, imm64, fe64);
        end
      end
      if (v64 && ir64) q64.push_back('{exp_imm, exp_err, tag_in});
    end
  end

  // Present one instruction to one DUT, starting just after a rising edge.
  task automatic drive(input int d, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [7:0] tg, input logic [63:0] ex);
    @(posedge clk); #1;
    instr   = ins;
    imm_sel = sel;
    tag_in  = tg;
    exp_imm = ex;
    exp_err = (sel == 3'd7);
    v32     = (d == 0);
    v64     = (d == 1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    v32     = 1'b0;
    v64     = 1'b0;
    err_clr = 1'b0;
  endtask

  logic [31:0] f_ins [5] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3,
                             32'h123450B7, 32'h0010006F};
  logic [63:0] f_exp [5] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8,
                             64'h12345000, 64'h00000800};

  initial begin
    rst_n = 1'b0; v32 = 0; v64 = 0; instr = '0; imm_sel = '0; tag_in = '0;
    out_ready = 1'b1; err_clr = 1'b0; exp_imm = '0; exp_err = 1'b0;
    #2;
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_in_ready",  64'(ir32), 64'd1);
    check("rst_imm",       64'(imm32), 64'd0);
    check("rst_tag",       64'(to32), 64'd0);
    check("rst_err_cnt",   64'(ec32), 64'd0);
    #10 rst_n = 1'b1;

    // Formats on XLEN=32, back-to-back: each result one cycle after accept.
    for (int i = 0; i < 5; i++) begin
      drive(0, f_ins[i], 3'(i), 8'(10 + i), f_exp[i]);
      @(negedge clk);
      check("lat_valid", 64'(ov32), (i > 0) ? 64'd1 : 64'd0);
      if (i > 0) check("lat_tag", 64'(to32), 64'(9 + i));
    end
    idle();
    @(negedge clk);
    check("lat_last_tag", 64'(to32), 64'd14);
    drive(0, 32'h03F01093, 3'd5, 8'd15, 64'h1F);
    idle();

    // XLEN=64 formats.
    drive(1, 32'h800000B7, 3'd3, 8'd20, 64'hFFFFFFFF80000000);
    drive(1, 32'h03F01093, 3'd5, 8'd21, 64'h000000000000003F);
    drive(1, 32'h000FD073, 3'd6, 8'd22, 64'h1F);
    drive(1, 32'hFFF00093, 3'd0, 8'd23, 64'hFFFFFFFFFFFFFFFF);
    idle();
    @(negedge clk);

    // Backpressure: tags 1,2 fill OR and SK; tag 3 is held upstream.
    out_ready = 1'b0;
    drive(0, 32'h00100093, 3'd0, 8'd1, 64'd1);
    @(negedge clk); check("bp_ready_1", 64'(ir32), 64'd1);
    drive(0, 32'h00200093, 3'd0, 8'd2, 64'd2);
    @(negedge clk); check("bp_ready_2", 64'(ir32), 64'd1);
    drive(0, 32'h00300093, 3'd0, 8'd3, 64'd3);
    @(negedge clk);
    check("bp_ready_low", 64'(ir32), 64'd0);
    check("bp_hold_tag",  64'(to32), 64'd1);
    @(posedge clk); @(negedge clk);
    check("bp_stable_tag",   64'(to32), 64'd1);
    check("bp_stable_valid", 64'(ov32), 64'd1);
    check("bp_stable_imm",   64'(imm32), 64'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); check("drain_tag1", 64'(to32), 64'd1);
    @(negedge clk);
    check("drain_tag2", 64'(to32), 64'd2);
    check("drain_ready_up", 64'(ir32), 64'd1);
    idle();
    @(negedge clk);
    check("drain_tag3", 64'(to32), 64'd3);
    check("drain_valid3", 64'(ov32), 64'd1);
    @(negedge clk); check("drain_empty", 64'(ov32), 64'd0);

    // Illegal selects on dut32.
    for (int i = 0; i < 3; i++) drive(0, 32'hFFFFFFFF, 3'd7, 8'(40 + i), 64'd0);
    idle();
    @(negedge clk); check("err_cnt32_3", 64'(ec32), 64'd3);

    // 2-bit counter saturates, then clear beats a coincident illegal accept.
    for (int i = 0; i < 5; i++) drive(1, 32'h12345678, 3'd7, 8'(50 + i), 64'd0);
    idle();
    @(negedge clk); check("err_cnt64_sat", 64'(ec64), 64'd3);
    drive(1, 32'h0, 3'd7, 8'd60, 64'd0);
    err_clr = 1'b1;
    idle();
    @(negedge clk); check("err_clr_prio", 64'(ec64), 64'd0);
    drive(1, 32'h0, 3'd7, 8'd61, 64'd0);
    idle();
    @(negedge clk); check("err_cnt64_after_clr", 64'(ec64), 64'd1);

    // Reset mid-stall with OR and SK both full.
    out_ready = 1'b0;
    drive(0, 32'h01000093, 3'd0, 8'h10, 64'h10);
    drive(0, 32'h01100093, 3'd0, 8'h11, 64'h11);
    idle();
    @(negedge clk);
    check("stall_full", 64'(ir32), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(ov32), 64'd0);
    check("arst_in_ready",  64'(ir32), 64'd1);
    check("arst_tag",       64'(to32), 64'd0);
    check("arst_err_cnt",   64'(ec32), 64'd0);
    q32.delete();
    q64.delete();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(0, 32'h02000093, 3'd0, 8'h20, 64'h20);
    idle();
    @(negedge clk);
    check("post_rst_valid", 64'(ov32), 64'd1);
    check("post_rst_tag",   64'(to32), 64'h20);
    @(negedge clk);
    check("post_rst_empty", 64'(ov32), 64'd0);

    check("sb32_drained", 64'(q32.size()), 64'd0);
    check("sb64_drained", 64'(q64.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
